// File: rtl/ula_16b_serial.sv
// ula_16b_serial: 16-bit 74181-style ALU built from one 4-bit slice reused over four nibble steps
module ula_74181 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cn_i,
  output logic [3:0] f_o,
  output logic       cn4_o,
  output logic       aeqb_o
);
  logic [3:0] x, y;
  logic [4:0] c;
  // x/y are the slice's per-bit propagate/generate terms; carries are active-high inside, active-low at the pins
  always_comb begin
    x = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
    y = (a_i & ~b_i & {4{s_i[2]}}) | (a_i & b_i & {4{s_i[3]}});
    c = '0;
    c[0] = ~cn_i;
    for (int i = 0; i < 4; i++) c[i+1] = y[i] | (x[i] & c[i]);
    f_o = x ^ y ^ ({4{m_i}} | c[3:0]);
    cn4_o = ~c[4];
    aeqb_o = &f_o;
  end
endmodule

module ula_16b_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  S,
  input  logic        M,
  input  logic        Cn,
  output logic [15:0] F,
  output logic        Cn16,
  output logic        AeqB,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [15:0] a_q, b_q, f_q;
  logic [3:0]  s_q;
  logic [1:0]  k_q;
  logic        m_q, cn_q, c_q, acc_q, cn16_q, aeqb_q, busy_q, done_q;
  logic [3:0]  nib_f_d;
  logic        nib_c_d, nib_eq_d, cn_d;
  assign cn_d = (k_q == 2'd0) ? cn_q : c_q;
  ula_74181 u_alu (
    .a_i   (a_q[{k_q, 2'b00} +: 4]),
    .b_i   (b_q[{k_q, 2'b00} +: 4]),
    .s_i   (s_q),
    .m_i   (m_q),
    .cn_i  (cn_d),
    .f_o   (nib_f_d),
    .cn4_o (nib_c_d),
    .aeqb_o(nib_eq_d)
  );
  // Request FSM: latch operands, step one nibble per RUN cycle, pulse done once, hold results in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      f_q     <= 16'h0000;
      acc_q   <= 1'b0;
      cn16_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= A;
          b_q     <= B;
          s_q     <= S;
          m_q     <= M;
          cn_q    <= Cn;
          k_q     <= 2'd0;
          f_q     <= 16'h0000;
          acc_q   <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          f_q[{k_q, 2'b00} +: 4] <= nib_f_d;
          c_q   <= nib_c_d;
          acc_q <= acc_q & nib_eq_d;
          k_q   <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            cn16_q  <= nib_c_d;
            aeqb_q  <= acc_q & nib_eq_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign F    = f_q;
  assign Cn16 = cn16_q;
  assign AeqB = aeqb_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ula_16b_serial.sv
// tb_ula_16b_serial: randomized and directed checks of the serial 16-bit ALU against a word-level model
module tb_ula_16b_serial;
  logic        clk, rst_n, start, M, Cn, Cn16, AeqB, busy, done;
  logic [15:0] A, B, F;
  logic [3:0]  S;
  int n_cmp = 0, n_bad = 0;

  ula_16b_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .S(S), .M(M), .Cn(Cn),
    .F(F), .Cn16(Cn16), .AeqB(AeqB), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // 74181 datasheet behaviour at word level: returns {Cn16, AeqB, F}
  function automatic logic [17:0] model(input logic [15:0] a, b, input logic [3:0] s, input logic m, cn);
    logic [15:0] p, g, lf, f;
    logic [16:0] sum;
    case (s)
      4'd0:  begin p = a;        g = 16'h0;  end
      4'd1:  begin p = a | b;    g = 16'h0;  end
      4'd2:  begin p = a | ~b;   g = 16'h0;  end
      4'd3:  begin p = 16'hFFFF; g = 16'h0;  end
      4'd4:  begin p = a;        g = a & ~b; end
      4'd5:  begin p = a | b;    g = a & ~b; end
      4'd6:  begin p = a;        g = ~b;     end
      4'd7:  begin p = 16'hFFFF; g = a & ~b; end
      4'd8:  begin p = a;        g = a & b;  end
      4'd9:  begin p = a;        g = b;      end
      4'd10: begin p = a | ~b;   g = a & b;  end
      4'd11: begin p = 16'hFFFF; g = a & b;  end
      4'd12: begin p = a;        g = a;      end
      4'd13: begin p = a | b;    g = a;      end
      4'd14: begin p = a | ~b;   g = a;      end
      default: begin p = 16'hFFFF; g = a;    end
    endcase
    case (s)
      4'd0:  lf = ~a;
      4'd1:  lf = ~(a | b);
      4'd2:  lf = ~a & b;
      4'd3:  lf = 16'h0000;
      4'd4:  lf = ~(a & b);
      4'd5:  lf = ~b;
      4'd6:  lf = a ^ b;
      4'd7:  lf = a & ~b;
      4'd8:  lf = ~a | b;
      4'd9:  lf = ~(a ^ b);
      4'd10: lf = b;
      4'd11: lf = a & b;
      4'd12: lf = 16'hFFFF;
      4'd13: lf = a | ~b;
      4'd14: lf = a | b;
      default: lf = a;
    endcase
    sum = {1'b0, p} + {1'b0, g} + {16'b0, ~cn};
    f = m ? lf : sum[15:0];
    return {~sum[16], &f, f};
  endfunction

  // Presents one request and releases start after the accepting edge; returns in cycle 1 of RUN
  task automatic issue(input logic [15:0] a, b, input logic [3:0] s, input logic m, cn);
    @(negedge clk);
    A = a; B = b; S = s; M = m; Cn = cn; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) lat = c;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; start = 0; A = 0; B = 0; S = 0; M = 0; Cn = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({F, Cn16, AeqB, busy, done} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_state got F=%h Cn16=%b AeqB=%b busy=%b done=%b want all zero", F, Cn16, AeqB, busy, done);
    end
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_xor;
    int lat, nb;
    issue(16'hA5C3, 16'h0FF0, 4'h6, 1'b1, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (lat != 5 || nb != 4) begin
      n_bad++;
      $display("FAIL xor_timing got done_cycle=%0d busy_cycles=%0d want 5 4", lat, nb);
    end
    n_cmp++;
    if (F !== 16'hAA33) begin
      n_bad++;
      $display("FAIL xor_result got %h want aa33", F);
    end
  endtask

  task automatic test_add;
    int lat, nb;
    issue(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (lat != 5 || F !== 16'h0100 || Cn16 !== 1'b1) begin
      n_bad++;
      $display("FAIL add_ripple got cyc=%0d F=%h Cn16=%b want 5 0100 1", lat, F, Cn16);
    end
    issue(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (lat != 5 || F !== 16'h0000 || Cn16 !== 1'b0) begin
      n_bad++;
      $display("FAIL add_carry_out got cyc=%0d F=%h Cn16=%b want 5 0000 0", lat, F, Cn16);
    end
  endtask

  task automatic test_compare;
    int lat, nb;
    issue(16'h3C3C, 16'h3C3C, 4'h6, 1'b0, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (lat != 5 || AeqB !== 1'b1 || F !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL compare_equal got cyc=%0d AeqB=%b F=%h want 5 1 ffff", lat, AeqB, F);
    end
    issue(16'h3C3C, 16'h3C3D, 4'h6, 1'b0, 1'b1);
    wait_done(lat, nb);
    n_cmp++;
    if (lat != 5 || AeqB !== 1'b0) begin
      n_bad++;
      $display("FAIL compare_diff got cyc=%0d AeqB=%b want 5 0", lat, AeqB);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (AeqB !== 1'b0 || F !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL hold_in_idle got AeqB=%b F=%h want 0 fffe", AeqB, F);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cn;
    logic [17:0] exp;
    int lat, nb;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); cn = 1'($urandom);
      if (i % 8 == 0) b = a;
      exp = model(a, b, s, m, cn);
      issue(a, b, s, m, cn);
      wait_done(lat, nb);
      n_cmp++;
      if (lat != 5 || {Cn16, AeqB, F} !== exp) begin
        n_bad++;
        $display("FAIL random_%0d A=%h B=%h S=%h M=%b Cn=%b got cyc=%0d {Cn16,AeqB,F}=%b_%b_%h want 5 %b_%b_%h",
                 i, a, b, s, m, cn, lat, Cn16, AeqB, F, exp[17], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_start_busy;
    logic [17:0] exp;
    int ndone;
    logic [17:0] got;
    exp = model(16'h1234, 16'h4321, 4'h9, 1'b0, 1'b0);
    ndone = 0; got = '0;
    issue(16'h1234, 16'h4321, 4'h9, 1'b0, 1'b0);
    @(negedge clk);
    A = 16'hFFFF; B = 16'h7777; S = 4'h6; M = 1'b1; Cn = 1'b1; start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 3; c <= 14; c++) begin
      if (c > 3) @(negedge clk);
      if (done) begin
        ndone++;
        got = {Cn16, AeqB, F};
      end
    end
    n_cmp++;
    if (ndone != 1 || got !== exp) begin
      n_bad++;
      $display("FAIL start_while_busy got dones=%0d result=%h want 1 %h", ndone, got, exp);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    issue(16'h5555, 16'h1111, 4'h9, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || F !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_mid_op got busy=%b done=%b F=%h want 0 0 0000", busy, done, F);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL aborted_no_done got dones=%0d want 0", ndone);
    end
  endtask

  task automatic test_reset_with_start;
    @(negedge clk);
    rst_n = 0; start = 1; A = 16'h0F0F; B = 16'h0101; S = 4'h9; M = 0; Cn = 1;
    @(negedge clk);
    rst_n = 1; start = 0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_over_start got busy=%b want 0", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_over_start_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_input_change;
    logic [17:0] exp;
    int lat;
    exp = model(16'h8421, 16'h1248, 4'h9, 1'b0, 1'b1);
    lat = 0;
    issue(16'h8421, 16'h1248, 4'h9, 1'b0, 1'b1);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done) lat = c;
      A = ~A; B = B ^ 16'h5A5A; S = S + 4'd1; M = ~M; Cn = ~Cn;
    end
    n_cmp++;
    if (lat != 5 || {Cn16, AeqB, F} !== exp) begin
      n_bad++;
      $display("FAIL input_change got cyc=%0d result=%h want 5 %h", lat, {Cn16, AeqB, F}, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp;
    int first, second;
    logic ok;
    exp = model(16'hBEEF, 16'h0421, 4'h6, 1'b0, 1'b0);
    first = 0; second = 0; ok = 1;
    @(negedge clk);
    A = 16'hBEEF; B = 16'h0421; S = 4'h6; M = 0; Cn = 0; start = 1;
    for (int c = 1; c <= 30 && second == 0; c++) begin
      @(negedge clk);
      if (done) begin
        if ({Cn16, AeqB, F} !== exp) ok = 0;
        if (first == 0) first = c;
        else second = c;
      end
    end
    start = 0;
    n_cmp++;
    if (first == 0 || second - first != 6 || !ok) begin
      n_bad++;
      $display("FAIL back_to_back got first=%0d second=%0d results_ok=%b want spacing 6 ok 1", first, second, ok);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back_stop got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset;
    test_xor;
    test_add;
    test_compare;
    test_random;
    test_start_busy;
    test_reset_mid;
    test_reset_with_start;
    test_input_change;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ula_16b_serial.md
ULA_16B_SERIAL -- requirements
Module: ula_16b_serial

Interface
REQ-001 The block SHALL instantiate exactly one ULA_74181 and time-multiplex it over four nibble steps to perform one 16-bit operation per request.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  16  operand A; sampled with start.
REQ-006 B  input  16  operand B; sampled with start.
REQ-007 S  input  4  74181 function select; sampled with start.
REQ-008 M  input  1  mode, 1 = logic, 0 = arithmetic; sampled with start.
REQ-009 Cn  input  1  carry into nibble 0, 74181 polarity; sampled with start.
REQ-010 F  output  16  registered result.
REQ-011 Cn16  output  1  registered Cn4 of nibble 3, 74181 polarity.
REQ-012 AeqB  output  1  registered AND of the four nibble AeqB outputs.
REQ-013 busy  output  1  high while a request is in progress.
REQ-014 done  output  1  one-cycle pulse marking a valid result.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL, at that edge, latch A, B, S, M and Cn, clear the nibble index to 0, clear the F/AeqB accumulators, and enter RUN.
REQ-017 In RUN, the ALU SHALL be driven with nibble k of the latched A and B (k=0 is bits 3:0), the latched S and M, and Cn = latched Cn when k=0 or the stored Cn4 of nibble k-1 when k>0.
REQ-018 Each RUN edge SHALL write the ALU F into F bits [4k+3:4k], store Cn4, AND the nibble AeqB into the running AeqB, and increment k.
REQ-019 The RUN edge with k=3 SHALL update F, Cn16 and AeqB together and enter DONE.
REQ-020 RUN SHALL last exactly 4 cycles.
REQ-021 Latency: done SHALL be high in the 5th cycle after the edge that accepted start.
REQ-022 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-023 busy SHALL be 1 in RUN only.
REQ-024 done SHALL be 1 in DONE only.
REQ-025 start SHALL be ignored in RUN and DONE; no queuing.
REQ-026 Back-to-back requests: a start held high continuously SHALL be accepted in the cycle after DONE, giving one result every 6 cycles.
REQ-027 Operand and control inputs SHALL be ignored after acceptance; input changes during RUN SHALL NOT alter the result.
REQ-028 F, Cn16 and AeqB SHALL hold their last completed values in IDLE until the next completion.
REQ-029 Intermediate F nibbles may be visible during RUN; a result is valid only while done=1.
REQ-030 In logic mode (M=1), Cn SHALL still be chained per REQ-017; Cn16 then carries no arithmetic meaning.
REQ-031 The 16-bit arithmetic SHALL equal a chained four-nibble 74181 ripple; no extra carry correction is applied.

Reset
REQ-032 rst_n=0 at an edge SHALL force the state to IDLE, k to 0, and F=16'h0000, Cn16=0, AeqB=0, busy=0 and done=0, from any state.
REQ-033 Reset SHALL override a simultaneous start.
REQ-034 A request aborted by reset SHALL produce no done pulse.

Verification
REQ-035 Logic XOR: M=1, S=4'h6, A=16'hA5C3, B=16'h0FF0, start pulse -> busy for 4 cycles, then done in the 5th cycle with F=16'hAA33.
REQ-036 Add with ripple: M=0, S=4'h9, Cn=1 (no carry), A=16'h00FF, B=16'h0001 -> F=16'h0100, carry propagated across nibbles 0-1; then A=16'hFFFF, B=16'h0001 -> F=16'h0000, Cn16 indicating carry-out (0).
REQ-037 Compare: M=0, S=4'h6, Cn=1, A=B=16'h3C3C -> done with AeqB=1 and F=16'hFFFF; repeat with B=16'h3C3D -> AeqB=0.
REQ-038 Start during busy: a second start pulse with different operands in RUN cycle 2 -> ignored, result matches the first request, exactly one done.
REQ-039 Reset mid-op: rst_n=0 for one cycle during RUN cycle 3 -> next cycle busy=0, done=0, F=16'h0000, and no done pulse follows.
REQ-040 Input change during RUN: A and B toggled every cycle after acceptance -> result equals the operation on the latched values.
